// File: rtl/action_pipe_arbiter_if.sv
// Avalon-ST style stream bundle; N lanes packed side by side (lane i at [i*W +: W]).
// Combinational only: no storage, no latency.
// ready flows opposite to the rest of the bundle; master drives valid/fields, slave drives ready.
interface action_pipe_arbiter_if #(
  parameter int N             = 1,
  parameter int DATA_WIDTH    = 600,
  parameter int EMPTY_WIDTH   = 7,
  parameter int CHANNEL_WIDTH = 6,
  parameter int ERROR_WIDTH   = 4,
  parameter int USER_WIDTH    = 132
) ();
  logic [N*DATA_WIDTH-1:0]    data;
  logic [N*EMPTY_WIDTH-1:0]   empty;
  logic [N-1:0]               valid;
  logic [N-1:0]               ready;
  logic [N-1:0]               startofpacket;
  logic [N-1:0]               endofpacket;
  logic [N*CHANNEL_WIDTH-1:0] channel;
  logic [N*ERROR_WIDTH-1:0]   error;
  logic [N*USER_WIDTH-1:0]    tuser;

  modport master (
    output data, empty, valid, startofpacket, endofpacket, channel, error, tuser,
    input  ready
  );

  modport slave (
    input  data, empty, valid, startofpacket, endofpacket, channel, error, tuser,
    output ready
  );
endinterface

// File: rtl/action_pipe_arbiter.sv
// Packet-level round-robin arbiter feeding the header action pipeline from S_COUNT ingress ports.
// Latency: 1 cycle arbitration per packet, then 1 cycle per beat through the output register.
// Backpressure: only the granted port sees ready, equal to (!m.valid || m.ready); others always stalled.
module action_pipe_arbiter #(
  parameter int S_COUNT       = 4,
  parameter int DATA_WIDTH    = 600,
  parameter int EMPTY_WIDTH   = 7,
  parameter int CHANNEL_WIDTH = 6,
  parameter int ERROR_WIDTH   = 4,
  parameter int USER_WIDTH    = 132,
  parameter int TAG_CHANNEL   = 0,
  localparam int GW           = (S_COUNT > 1) ? $clog2(S_COUNT) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  action_pipe_arbiter_if.slave  s,
  action_pipe_arbiter_if.master m,
  output logic [GW-1:0]         grant_port,
  output logic                  busy,
  output logic                  protocol_err
);

  // Tagging the channel with the port index needs the index to fit in the channel field.
  generate
    if (TAG_CHANNEL != 0 && GW > CHANNEL_WIDTH) begin : g_tag_width_check
      $error("action_pipe_arbiter: port index does not fit in CHANNEL_WIDTH");
    end
  endgenerate

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    PKT  = 1'b1
  } state_t;

  state_t                   state;
  logic [GW-1:0]            rr_ptr;
  logic                     first_beat;

  logic                     out_free;
  logic                     accept;
  logic                     pick_found;
  logic [GW-1:0]            pick_idx;

  logic [DATA_WIDTH-1:0]    sel_data;
  logic [EMPTY_WIDTH-1:0]   sel_empty;
  logic                     sel_valid;
  logic                     sel_sop;
  logic                     sel_eop;
  logic [CHANNEL_WIDTH-1:0] sel_channel;
  logic [ERROR_WIDTH-1:0]   sel_error;
  logic [USER_WIDTH-1:0]    sel_tuser;

  // Output register can take a new beat when empty or being drained this cycle.
  assign out_free = !m.valid[0] || m.ready[0];
  assign accept   = (state == PKT) && sel_valid && out_free;

  // Mux the granted port's lane; only meaningful while in PKT.
  always_comb begin
    sel_data    = s.data[grant_port*DATA_WIDTH +: DATA_WIDTH];
    sel_empty   = s.empty[grant_port*EMPTY_WIDTH +: EMPTY_WIDTH];
    sel_valid   = s.valid[grant_port];
    sel_sop     = s.startofpacket[grant_port];
    sel_eop     = s.endofpacket[grant_port];
    sel_channel = s.channel[grant_port*CHANNEL_WIDTH +: CHANNEL_WIDTH];
    sel_error   = s.error[grant_port*ERROR_WIDTH +: ERROR_WIDTH];
    sel_tuser   = s.tuser[grant_port*USER_WIDTH +: USER_WIDTH];
  end

  // Round-robin search starting just after the last winner; descending loop so the nearest valid port wins.
  always_comb begin
    int idx;
    idx        = 0;
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int k = S_COUNT; k >= 1; k--) begin
      idx = (int'(rr_ptr) + k) % S_COUNT;
      if (s.valid[idx]) begin
        pick_found = 1'b1;
        pick_idx   = GW'(idx);
      end
    end
  end

  // Only the granted port is ever offered ready, and only while a packet is in flight.
  always_comb begin
    s.ready = '0;
    if (state == PKT) begin
      s.ready[grant_port] = out_free;
    end
  end

  // Grant FSM: arbitrate in IDLE, hold the grant through EOP in PKT, flag SOP misuse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      grant_port   <= '0;
      rr_ptr       <= GW'(S_COUNT - 1);
      busy         <= 1'b0;
      first_beat   <= 1'b0;
      protocol_err <= 1'b0;
    end else begin
      protocol_err <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_found) begin
            grant_port <= pick_idx;
            state      <= PKT;
            busy       <= 1'b1;
            first_beat <= 1'b1;
          end
        end
        PKT: begin
          if (accept) begin
            first_beat   <= 1'b0;
            // The first beat must open the packet and no later beat may reopen it.
            protocol_err <= first_beat ? !sel_sop : sel_sop;
            if (sel_eop) begin
              rr_ptr <= grant_port;
              state  <= IDLE;
              busy   <= 1'b0;
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Output stage: load on accept, drop valid once drained, hold fields while stalled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      m.valid         <= '0;
      m.data          <= '0;
      m.empty         <= '0;
      m.startofpacket <= '0;
      m.endofpacket   <= '0;
      m.channel       <= '0;
      m.error         <= '0;
      m.tuser         <= '0;
    end else if (accept) begin
      m.valid         <= 1'b1;
      m.data          <= sel_data;
      m.empty         <= sel_empty;
      m.startofpacket <= sel_sop;
      m.endofpacket   <= sel_eop;
      m.channel       <= (TAG_CHANNEL != 0) ? CHANNEL_WIDTH'(grant_port) : sel_channel;
      m.error         <= sel_error;
      m.tuser         <= sel_tuser;
    end else if (m.ready[0]) begin
      m.valid         <= 1'b0;
    end
  end

endmodule
